// File: rtl/regbank_wb_queue.sv
// regbank_wb_queue: FIFO of pending register-bank writebacks {addr, data}.
// The head entry drives the bank write port whenever the queue is occupied
// and hold is low. Pending entries can be forwarded to two read ports.
// Build option: define REGBANK_WB_FWD_EN to include the forwarding comparators.
// When it is undefined, the forwarding outputs are tied to zero.
module regbank_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  input  logic                     hold,
  output logic                     write,
  output logic [4:0]               addr_d,
  output logic [31:0]              data,
  input  logic [4:0]               fwd_addr_a,
  input  logic [4:0]               fwd_addr_b,
  output logic                     fwd_hit_a,
  output logic                     fwd_hit_b,
  output logic [31:0]              fwd_data_a,
  output logic [31:0]              fwd_data_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]  mem_addr_q [DEPTH];
  logic [31:0] mem_data_q [DEPTH];

  logic push;
  logic pop;
  logic occupied;

  // Handshake and bank write port, driven only from registered occupancy.
  always_comb begin
    occupied = (count_q != '0);
    in_ready = (count_q < CW'(DEPTH));
    write    = occupied && !hold;
    push     = in_valid && in_ready;
    pop      = write;
    addr_d   = occupied ? mem_addr_q[head_q] : '0;
    data     = occupied ? mem_data_q[head_q] : '0;
    count    = count_q;
  end

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; no reset needed because occupancy gates every output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[tail_q] <= in_addr;
      mem_data_q[tail_q] <= in_data;
    end
  end

`ifdef REGBANK_WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest from the head so the youngest match wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    fwd_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (mem_addr_q[fwd_idx] == fwd_addr_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = mem_data_q[fwd_idx];
        end
        if (mem_addr_q[fwd_idx] == fwd_addr_b) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = mem_data_q[fwd_idx];
        end
      end
    end
  end

  logic unused_fwd;
  assign unused_fwd = 1'b0;
`else
  logic unused_fwd;

  // Forwarding not built: outputs are constant zero.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    unused_fwd = ^{fwd_addr_a, fwd_addr_b};
  end
`endif

endmodule
